// File: rtl/rca_pkg.sv
// Shared constants and a reference adder for the ripple-carry adder block.
package rca_pkg;

   localparam int DEFAULT_PROC_SIZE = 16;
   localparam int MAX_PROC_SIZE     = 64;

   // Reference a+b for operands of 'width' bits; bit 'width' of the result is the carry out.
   function automatic logic [MAX_PROC_SIZE:0] rca_ref_sum(input logic [MAX_PROC_SIZE-1:0] a,
                                                          input logic [MAX_PROC_SIZE-1:0] b,
                                                          input int unsigned              width);
      logic [MAX_PROC_SIZE-1:0] mask;
      mask = (width >= MAX_PROC_SIZE) ? '1 : ((64'd1 << width) - 64'd1);
      return {1'b0, a & mask} + {1'b0, b & mask};
   endfunction

endpackage

// File: rtl/rca_full_adder.sv
// One-bit full adder cell used as the ripple-carry chain element.
module full_adder
   import rca_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/rca.sv
// Registered ripple-carry adder: PROC_SIZE chained full adders, one output register stage.
module rca
   import rca_pkg::*;
#(
   parameter int PROC_SIZE = DEFAULT_PROC_SIZE
) (
   input  logic [PROC_SIZE-1:0] a,
   input  logic [PROC_SIZE-1:0] b,
   output logic [PROC_SIZE-1:0] sum,
   output logic                 cout,
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 out_valid
);

   logic [PROC_SIZE:0]   w_carry;
   logic [PROC_SIZE-1:0] w_sum;
   logic [PROC_SIZE-1:0] r_sum;
   logic                 r_cout;
   logic                 r_valid;

   assign w_carry[0] = 1'b0;

   for (genvar i = 0; i < PROC_SIZE; i++) begin : g_fa
      full_adder u_fa (
         .x  (a[i]),
         .y  (b[i]),
         .ci (w_carry[i]),
         .s  (w_sum[i]),
         .co (w_carry[i+1])
      );
   end

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so order inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[PROC_SIZE];
         end
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_rca.sv
// Self-checking bench for rca: directed vector table, reset corners, random width sweep.
module tb_rca;
   import rca_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] a16, b16, sum16;
   logic        cout16, iv16, ov16;
   logic [0:0]  a1, b1, sum1;
   logic        cout1, ov1;
   logic [3:0]  a4, b4, sum4;
   logic        cout4, ov4;
   logic [31:0] a32, b32, sum32;
   logic        cout32, ov32;
   logic        sw_valid;

   int n_checks = 0;
   int n_fail   = 0;

   rca dut (
      .a(a16), .b(b16), .sum(sum16), .cout(cout16),
      .clk(clk), .rst(rst), .in_valid(iv16), .out_valid(ov16)
   );
   rca #(.PROC_SIZE(1)) dut1 (
      .a(a1), .b(b1), .sum(sum1), .cout(cout1),
      .clk(clk), .rst(rst), .in_valid(sw_valid), .out_valid(ov1)
   );
   rca #(.PROC_SIZE(4)) dut4 (
      .a(a4), .b(b4), .sum(sum4), .cout(cout4),
      .clk(clk), .rst(rst), .in_valid(sw_valid), .out_valid(ov4)
   );
   rca #(.PROC_SIZE(32)) dut32 (
      .a(a32), .b(b32), .sum(sum32), .cout(cout32),
      .clk(clk), .rst(rst), .in_valid(sw_valid), .out_valid(ov32)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        iv;
      logic [15:0] sum;
      logic        cout;
      logic        ov;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check16(input string name, input logic [15:0] s, input logic c, input logic v);
      check({name, ".sum"},  64'(sum16),  64'(s));
      check({name, ".cout"}, 64'(cout16), 64'(c));
      check({name, ".ov"},   64'(ov16),   64'(v));
   endtask

   vec_t        vecs[8];
   logic [15:0] exp_sum;
   logic        exp_cout;
   logic [16:0] full16;
   logic [64:0] ref_v;

   initial begin
      vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
      vecs[1] = '{16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b1};
      vecs[2] = '{16'h1234, 16'h1111, 1'b0, 16'h0003, 1'b0, 1'b0};
      vecs[3] = '{16'h0009, 16'h000A, 1'b1, 16'h0013, 1'b0, 1'b1};
      vecs[4] = '{16'h000F, 16'h000F, 1'b1, 16'h001E, 1'b0, 1'b1};
      vecs[5] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b1};
      vecs[7] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFE, 1'b1, 1'b0};

      a1 = '0; b1 = '0; a4 = '0; b4 = '0; a32 = '0; b32 = '0;
      sw_valid = 1'b1;

      // Reset held for two cycles with all-ones operands presented.
      rst = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check16($sformatf("reset%0d", i), 16'h0000, 1'b0, 1'b0);
      end

      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a16 = vecs[i].a; b16 = vecs[i].b; iv16 = vecs[i].iv;
         tick();
         check16($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ov);
      end

      // Reset wins over a valid operation in the same cycle.
      rst = 1'b1; a16 = 16'h8000; b16 = 16'h8000; iv16 = 1'b1;
      tick();
      check16("rst_mid", 16'h0000, 1'b0, 1'b0);
      rst = 1'b0; iv16 = 1'b0;
      tick();
      check16("post_rst_idle", 16'h0000, 1'b0, 1'b0);
      a16 = 16'h0003; b16 = 16'h0004; iv16 = 1'b1;
      tick();
      check16("first_after_rst", 16'h0007, 1'b0, 1'b1);
      exp_sum = 16'h0007; exp_cout = 1'b0;

      // Random sweep: 16-bit instance with random in_valid, 1/4/32-bit instances every cycle.
      for (int n = 0; n < 1000; n++) begin
         a16  = 16'($urandom); b16 = 16'($urandom);
         iv16 = ($urandom_range(0, 3) != 0);
         a1   = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
         a4   = 4'($urandom); b4 = 4'($urandom);
         a32  = $urandom; b32 = $urandom;
         if (n < 4) begin
            a32 = (n[0]) ? 32'hFFFF_FFFF : 32'h0000_0001;
            b32 = 32'hFFFF_FFFF;
         end
         if (iv16) begin
            full16   = 17'(a16) + 17'(b16);
            exp_sum  = full16[15:0];
            exp_cout = full16[16];
         end
         tick();
         check16("rand16", exp_sum, exp_cout, iv16);
         ref_v = rca_ref_sum(64'(a1), 64'(b1), 1);
         check("w1", 64'({cout1, sum1}), ref_v[63:0]);
         ref_v = rca_ref_sum(64'(a4), 64'(b4), 4);
         check("w4", 64'({cout4, sum4}), ref_v[63:0]);
         ref_v = rca_ref_sum(64'(a32), 64'(b32), 32);
         check("w32", 64'({cout32, sum32}), ref_v[63:0]);
         check("sweep_ov", 64'({ov1, ov4, ov32}), 64'h7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
